// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential M-extension multiply/divide unit.
package muldiv_seq_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Datapath for muldiv_seq: magnitude shift-add multiply, restoring divide,
// special-case capture and the final sign fix-up into the result register.
module muldiv_dp
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            special,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic              is_div_in, signed_a_in, signed_b_in;
    logic              sign_a_in, sign_b_in, div0_in, ovf_in, sel_hi_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;

    logic              is_div, sel_hi, neg, sign_a, div0, ovf;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] prod;

    logic [XLEN-1:0]   prod_hi, prod_lo;
    logic [XLEN:0]     add_sum, shifted, sub_try;
    logic [2*XLEN-1:0] mul_next, div_next, mul_full;
    logic [XLEN-1:0]   quo, rem, fix_val;

    assign prod_hi = prod[2*XLEN-1:XLEN];
    assign prod_lo = prod[XLEN-1:0];

    always_comb begin
        is_div_in   = func3[2];
        signed_a_in = (func3 != F3_MUL) && (func3 != F3_MULHU) &&
                      (func3 != F3_DIVU) && (func3 != F3_REMU);
        signed_b_in = signed_a_in && (func3 != F3_MULHSU);
        sign_a_in   = signed_a_in && rs1[XLEN-1];
        sign_b_in   = signed_b_in && rs2[XLEN-1];
        mag_a_in    = sign_a_in ? -rs1 : rs1;
        mag_b_in    = sign_b_in ? -rs2 : rs2;
        div0_in     = is_div_in && (rs2 == '0);
        ovf_in      = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                      (rs1 == MIN_VAL) && (rs2 == '1);
        special     = div0_in || ovf_in;
        sel_hi_in   = is_div_in ? ((func3 == F3_REM) || (func3 == F3_REMU))
                                : (func3 != F3_MUL);
    end

    // Multiply and divide share the product register: {acc/remainder, multiplier/quotient}.
    always_comb begin
        add_sum  = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next = {add_sum, prod_lo[XLEN-1:1]};
        shifted  = {prod_hi, prod_lo[XLEN-1]};
        sub_try  = shifted - {1'b0, opnd};
        div_next = sub_try[XLEN] ? {shifted[XLEN-1:0], prod_lo[XLEN-2:0], 1'b0}
                                 : {sub_try[XLEN-1:0], prod_lo[XLEN-2:0], 1'b1};
    end

    always_comb begin
        mul_full = neg ? -prod : prod;
        quo      = neg ? -prod_lo : prod_lo;
        rem      = sign_a ? -prod_hi : prod_hi;
        if (div0) begin
            quo = '1;
            rem = prod_lo;
        end else if (ovf) begin
            quo = prod_lo;
            rem = '0;
        end
        if (is_div)
            fix_val = sel_hi ? rem : quo;
        else
            fix_val = sel_hi ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    end

    // Special cases park the raw dividend in the low half so FIX can return it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div <= 1'b0;
            sel_hi <= 1'b0;
            neg    <= 1'b0;
            sign_a <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            opnd   <= '0;
            prod   <= '0;
            result <= '0;
        end else begin
            if (load) begin
                is_div <= is_div_in;
                sel_hi <= sel_hi_in;
                neg    <= sign_a_in ^ sign_b_in;
                sign_a <= sign_a_in;
                div0   <= div0_in;
                ovf    <= ovf_in;
                opnd   <= is_div_in ? mag_b_in : mag_a_in;
                if (special)
                    prod <= {{XLEN{1'b0}}, rs1};
                else
                    prod <= {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
            end else if (step) begin
                prod <= is_div ? div_next : mul_next;
            end
            if (fix)
                result <= fix_val;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequencing FSM for the iterative M-extension unit; the arithmetic lives in muldiv_dp.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load, step, fix, special;

    assign load = (state == IDLE) && start;
    assign step = (state == RUN);
    assign fix  = (state == FIX);

    // valid rises on the edge that leaves DONE, so it is seen in the first IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= CNT_W'(XLEN - 1);
                        busy  <= 1'b1;
                        state <= special ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    muldiv_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .special(special),
        .result (result)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expectations, a monitor checks each valid pulse.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          lat;
        int          e0;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic valid_prev = 1'b0;
    exp_t sb_q[$];

    muldiv_seq #(
        .XLEN(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .func3 (func3),
        .rs1   (rs1),
        .rs2   (rs2),
        .busy  (busy),
        .valid (valid),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pop one expectation per valid pulse and check result, latency and pulse width.
    always @(negedge clk) begin
        exp_t item;
        if (valid_prev)
            check_output("valid_width", {31'b0, valid}, 32'h0);
        if (valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got result 0x%08h, expected no valid", result);
            end else begin
                item = sb_q.pop_front();
                check_output({item.name, "_result"}, result, item.exp);
                check_output({item.name, "_latency"}, 32'(cyc - item.e0), 32'(item.lat));
            end
        end
        valid_prev = valid;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=1, expected busy=0 within 200 cycles");
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp, input int lat);
        exp_t item;
        wait_idle();
        start = 1'b1;
        func3 = f;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        item.name = name;
        item.exp  = exp;
        item.lat  = lat;
        item.e0   = cyc;
        sb_q.push_back(item);
        start = 1'b0;
        func3 = 3'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    initial begin
        int busy_cnt;
        int n;
        logic saw_valid;

        rst   = 1'b1;
        start = 1'b0;
        func3 = 3'b000;
        rs1   = '0;
        rs2   = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        check_output("reset_valid", {31'b0, valid}, 32'h0);
        check_output("reset_result", result, 32'h0);
        rst = 1'b0;

        apply_stimulus("mul_7_m3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
        end
        check_output("busy_cycles", 32'(busy_cnt), 32'd34);

        apply_stimulus("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        apply_stimulus("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        apply_stimulus("mulhsu_ff", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        apply_stimulus("mul_ff", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        apply_stimulus("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        apply_stimulus("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        apply_stimulus("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        apply_stimulus("div_min_2", F3_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);

        // A start pulse mid-RUN with other operands must not disturb the running divide.
        apply_stimulus("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
        repeat (5) @(negedge clk);
        start = 1'b1;
        func3 = F3_MUL;
        rs1   = 32'd3;
        rs2   = 32'd5;
        @(negedge clk);
        start = 1'b0;

        apply_stimulus("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
        apply_stimulus("divu_min_ff", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        apply_stimulus("remu_min_ff", F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        apply_stimulus("divu_5_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        apply_stimulus("rem_5_0", F3_REM, 32'd5, 32'd0, 32'd5, 2);
        apply_stimulus("rem_m7_0", F3_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        apply_stimulus("div_min_0", F3_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 2);
        apply_stimulus("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        apply_stimulus("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Abort an operation with reset partway through RUN.
        apply_stimulus("aborted", F3_MUL, 32'd3, 32'd3, 32'd9, 34);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        sb_q.delete();
        check_output("abort_busy", {31'b0, busy}, 32'h0);
        check_output("abort_valid", {31'b0, valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        check_output("abort_no_valid", {31'b0, saw_valid}, 32'h0);

        apply_stimulus("mulhu_post_rst", F3_MULHU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 34);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative M-extension execution unit with its own sequencing FSM. It serves MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for the multi-cycle core. The EX-stage control raises start, and the main FSM holds in EX until valid pulses. It uses shift-add multiply and restoring divide over magnitudes, followed by a one-cycle sign fix-up.

Parameters:
XLEN, 32, operand/result width; must be a power of 2 and at least 8
CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
func3  in  3  M-extension func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
rs1  in  XLEN  operand A (dividend / multiplicand)
rs2  in  XLEN  operand B (divisor / multiplier)
busy  out  1  high whenever state != IDLE
valid  out  1  one-cycle pulse, result is final
result  out  XLEN  result; held stable from valid until the next accepted start

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: state=IDLE, busy=0, valid=0, result=0, counter=0, internal regs=0. Assertion mid-operation aborts immediately; no valid is produced for the aborted op.
- States:
  - IDLE: start=1 latches func3, rs1 and rs2. Records signs per op: MULH/DIV/REM both signed; MULHSU rs1 signed only; others unsigned. Loads magnitudes and counter=XLEN-1.
  - From IDLE, the next state is FIX for the special cases below, else RUN.
  - RUN: one iteration per cycle. Counter decrements; when counter==0, next state is FIX. RUN lasts exactly XLEN cycles.
  - FIX: applies sign correction and selects the output half. Writes result. Next state is DONE.
  - DONE: valid=1 for this cycle only, then IDLE.
- Multiply:
  - 2*XLEN product register, shift-add on magnitude of rs2 LSB-first.
  - Product is negated in FIX if signA^signB.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide:
  - Restoring: remainder/quotient shift, trial subtract, quotient bit = no-borrow.
  - Quotient is negated if signA^signB; remainder takes the sign of the dividend.
- Special cases (skip RUN):
  - Divisor==0: quotient all-ones; remainder = rs1 unmodified.
  - Signed overflow (DIV/REM, rs1=1<<(XLEN-1), rs2=all-ones): quotient=rs1; remainder=0.
- Latency, counted from the accepting edge E0:
  - Normal: valid high in the cycle after edge E0+XLEN+2 (34 cycles for XLEN=32).
  - Special case: valid after E0+2.
- start while busy=1 (including DONE) is ignored; operands are not re-sampled.
- start held high continuously: a new op is accepted on the first IDLE cycle after DONE.
- Operands are registered at E0. rs1, rs2 and func3 may change freely after E0.
- Width rules:
  - Magnitude of the most-negative value is 1<<(XLEN-1) and is treated as unsigned. No overflow occurs in the magnitude path.
  - Negation is two's complement over the full 2*XLEN product or XLEN quotient/remainder.

Decomposition:
- Shared package:
  - func3 encodings for the M extension as named constants.
  - FSM state encoding (IDLE=2'b00, RUN=2'b01, FIX=2'b10, DONE=2'b11).
  - XLEN default.
- The FSM, counter and handshake stay in muldiv_seq.
- One sub-module, muldiv_dp, holds the datapath: operand/product/remainder registers, one-step shift-add/trial-subtract logic, and the fix-up negation. It is controlled by load/step/fix strobes from the FSM.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; valid one cycle, 34 cycles after start edge; busy high for 34 cycles.
- rs1=rs2=0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
  - MUL -> 0x00000001
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REM 5/0 -> 5
  - DIV 0x80000000/0 -> 0xFFFFFFFF
  - Each with valid 2 cycles after start.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; valid latency 2.
- Pulse start at cycle 5 of a RUN with different operands -> ignored, first result unchanged. Assert rst mid-RUN -> busy=0, valid never pulses. New start after release -> correct result with full latency.
